// File: rtl/ram_frame_ctrl_if.sv
// Valid/ready word stream between the frame buffer and its neighbours.
// The producer drives data/valid/last; the consumer answers with ready.
interface ram_frame_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/ram_frame_ctrl.sv
// Frame buffer initiator: fills FRAME_LEN words into a single-port ram,
// then streams them back out in address order before accepting more.
module ram_frame_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10,
    parameter int FRAME_LEN     = 160
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ram_frame_ctrl_if.slave          in_s,
    ram_frame_ctrl_if.master         out_s,
    output logic [DATA_WIDTH-1:0]    ram_data_o,
    output logic                     ram_write_en_o,
    output logic [ADDRESS_WIDTH-1:0] ram_address_o,
    input  logic [DATA_WIDTH-1:0]    ram_data_i,
    output logic                     frame_done_o
);
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t                state;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  done_q;
    logic                  in_ready;
    logic                  wr_en;
    logic                  xfer;
    logic                  load;

    assign in_ready = (state == FILL);
    assign wr_en    = in_s.valid & in_ready;
    assign xfer     = out_valid_q & out_s.ready;
    // Refill the output register whenever it is empty or being drained.
    assign load     = (state == DRAIN) & (!out_valid_q | out_s.ready)
                    & (rd_cnt < LEN);

    assign in_s.ready     = in_ready;
    assign ram_data_o     = in_s.data;
    assign ram_write_en_o = wr_en;
    assign ram_address_o  = in_ready ? wr_cnt[ADDRESS_WIDTH-1:0]
                                     : rd_cnt[ADDRESS_WIDTH-1:0];

    assign out_s.data  = out_data_q;
    assign out_s.valid = out_valid_q;
    assign out_s.last  = out_last_q;
    assign frame_done_o = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                FILL: begin
                    if (wr_en) begin
                        if (wr_cnt == LAST) begin
                            state  <= DRAIN;
                            wr_cnt <= '0;
                            rd_cnt <= '0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer & out_last_q) begin
                        state       <= FILL;
                        rd_cnt      <= '0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (load) begin
                        out_data_q  <= ram_data_i;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rd_cnt == LAST);
                        rd_cnt      <= rd_cnt + 1'b1;
                    end else if (xfer) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
